ant_symbol_serializer: RTL
==========================

# ant_symbol_serializer

Rebuilds a continuous, in-order antenna symbol stream from the addressed half-symbol stream that the antenna symbol buffers produce. Each input word carries its own sequence address.
- Words are written by address into a two-bank ping-pong RAM.
- A bank is released for reading once its last word has arrived.
- The bank is then read out sequentially, addresses 0 to SYM_LEN-1, through a small output FIFO with ready/valid backpressure.

The block sits between the dimension-reduction datapath and the CPRI transmit framer.

## Interface
- DATA_WIDTH, 64, width of one data word.
- ADDR_WIDTH, 11, width of the sequence address.
- SYM_LEN, 1584, words per half symbol; also the depth of each bank.

- i_clk  in  1  single clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  DATA_WIDTH  input word.
- i_rx_addr  in  ADDR_WIDTH  sequence address of i_rx_data.
- i_rx_last  in  1  marks the final word of a half symbol.
- i_rvalid  in  1  input qualifier; there is no input backpressure.
- o_tx_data  out  DATA_WIDTH  output word.
- o_tx_valid  out  1  output word valid.
- i_tready  in  1  downstream ready.
- o_tx_sop  out  1  high with word 0.
- o_tx_eop  out  1  high with word SYM_LEN-1.
- o_sym_cnt  out  8  count of completed output symbols; wraps at 255.
- o_overflow  out  1  sticky: a symbol was dropped because its bank was still full.
- o_addr_err  out  1  sticky: a write arrived with i_rx_addr >= SYM_LEN.
- o_len_err  out  1  sticky, optional: a symbol closed with the wrong word count (see Configuration).

## Operation
**Write side**
- A write is accepted when i_rvalid is high. It goes to bank wr_bank at location i_rx_addr.
- If i_rx_addr >= SYM_LEN, the write is discarded and o_addr_err is set.
- At the first write of a symbol, the block samples full[wr_bank]. If that bank is full:
  - all writes of the symbol, through and including the one with i_rx_last, are discarded;
  - o_overflow is set;
  - wr_bank is not toggled.
- On an accepted write with i_rx_last and no drop, the block sets full[wr_bank] and toggles wr_bank.

**Read FSM**, states IDLE, READ:
- IDLE: when full[rd_bank] is set, load rd_addr=0 and go to READ.
- READ: issue a RAM read at (rd_bank, rd_addr) whenever FIFO occupancy plus in-flight reads is less than 4. rd_addr then increments.
- When rd_addr SYM_LEN-1 is issued:
  - clear full[rd_bank];
  - toggle rd_bank;
  - return to IDLE.
- sop and eop tags travel with each read into the FIFO.

**RAM and output FIFO**
- RAM read latency is 1 cycle. Returned data enters a 4-entry FIFO.
- A word is popped on o_tx_valid && i_tready.
- o_sym_cnt increments on every popped eop word.

**Boundary rules**
- Set and clear of the same full flag in one cycle cannot occur, because writes to a full bank are dropped.
- Set of one bank and clear of the other in the same cycle are independent.
- The FIFO never overflows, because of the credit check on read issue.
- o_tx_data, o_tx_sop and o_tx_eop are held while o_tx_valid && !i_tready.
- Sticky flags clear only on reset.

## Timing
- Reset value of every output is 0. Reset also clears:
  - wr_bank, rd_bank, both full flags;
  - the FSM, which returns to IDLE;
  - FIFO pointers, all sticky flags, and the drop state.
- Reset asserted mid-symbol abandons all partially written and partially read data.
- Latency with an empty FIFO:
  - Edge T samples i_rvalid && i_rx_last.
  - full set at T+1.
  - Read of addr 0 issued at T+2.
  - o_tx_valid with word 0 and o_tx_sop high at T+3.
- With i_tready held high, output is one word per cycle with no bubbles. A symbol takes SYM_LEN consecutive cycles.
- Back-to-back symbols are separated by exactly 1 bubble cycle, for the IDLE→READ turn.
- The input may deliver words in any address order within a symbol. Only i_rx_last closes the symbol.

## Configuration
- Macro SYM_LEN_CHECK_EN.
- Defined:
  - A per-symbol accepted-write counter resets at each symbol start.
  - On i_rx_last, if count != SYM_LEN, o_len_err is set.
  - The symbol is still released for reading.
- Undefined: the counter is not built and o_len_err is tied to 0.

## Test plan
- Ascending-address fill: write 1584 words with addresses 0..1583 and data = addr, last on 1583, i_tready=1.
  - o_tx_valid rises 3 cycles after the last word.
  - 1584 consecutive words, data 0..1583.
  - sop on word 0, eop on word 1583, o_sym_cnt=1.
- Reverse-address fill: write addresses 1583 down to 0, with last on addr 0.
  - Output is still ascending data 0..1583.
- Three symbols back to back with the reader stalled (i_tready=0).
  - Symbols 1 and 2 fill both banks. Symbol 3 is dropped and o_overflow=1.
  - After releasing i_tready, exactly 3168 words are output: symbols 1 then 2.
- Backpressure: toggle i_tready randomly at 50%.
  - Output is loss-free and in order, with data stable during stalls.
- Address error: write addr 1600 mid-symbol.
  - o_addr_err=1, and the RAM is unchanged at all addresses.
  - With SYM_LEN_CHECK_EN, o_len_err=1 at last. The symbol then has only 1583 valid writes, because the addr-1600 word replaced one of the in-range addresses.
- Reset mid-read: assert i_reset_n=0 at word 700 of the output.
  - All outputs are 0 immediately.
  - After release, a fresh full symbol outputs correctly with o_sym_cnt=1.

Source files
------------

// File: rtl/ant_symbol_serializer.sv
// Ping-pong reorder buffer: addressed half-symbol words in, in-order stream out via a 4-entry FIFO.
// Optional build macro SYM_LEN_CHECK_EN adds the per-symbol word-count check driving o_len_err.
module ant_symbol_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 11,
  parameter int SYM_LEN    = 1584
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [ADDR_WIDTH-1:0] i_rx_addr,
  input  logic                  i_rx_last,
  input  logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tready,
  output logic                  o_tx_sop,
  output logic                  o_tx_eop,
  output logic [7:0]            o_sym_cnt,
  output logic                  o_overflow,
  output logic                  o_addr_err,
  output logic                  o_len_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SYM_LEN - 1);

  typedef enum logic {IDLE, READ} rd_state_t;

  // ---------------------------------------------------------------- write side
  logic       wr_bank_q;
  logic       in_sym_q;
  logic       drop_q;
  logic [1:0] full_q;
  logic       overflow_q;
  logic       addr_err_q;

  logic       addr_ok;
  logic       wr_first;
  logic       wr_drop;
  logic       wr_en;
  logic       close_sym;
  logic [1:0] full_set;
  logic [1:0] full_clr;

  assign addr_ok = (i_rx_addr <= LAST_ADDR);

  // The drop decision is frozen at the first word of a symbol and held until its last word.
  always_comb begin
    wr_first    = !in_sym_q;
    wr_drop     = wr_first ? full_q[wr_bank_q] : drop_q;
    wr_en       = i_rvalid && !wr_drop && addr_ok;
    close_sym   = i_rvalid && i_rx_last && !wr_drop;
    full_set[0] = close_sym && !wr_bank_q;
    full_set[1] = close_sym &&  wr_bank_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_bank_q  <= 1'b0;
      in_sym_q   <= 1'b0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (i_rvalid) begin
      if (!addr_ok)
        addr_err_q <= 1'b1;
      if (wr_first && full_q[wr_bank_q])
        overflow_q <= 1'b1;
      if (i_rx_last) begin
        in_sym_q <= 1'b0;
        drop_q   <= 1'b0;
        if (!wr_drop)
          wr_bank_q <= ~wr_bank_q;
      end else begin
        in_sym_q <= 1'b1;
        drop_q   <= wr_drop;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      full_q <= '0;
    else
      full_q <= (full_q | full_set) & ~full_clr;
  end

`ifdef SYM_LEN_CHECK_EN
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] SYM_LEN_CNT = CNT_W'(SYM_LEN);

  logic [CNT_W-1:0] len_cnt_q;
  logic [CNT_W-1:0] len_cnt_cur;
  logic             len_err_q;

  always_comb begin
    len_cnt_cur = (wr_first ? '0 : len_cnt_q) + CNT_W'(wr_en);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      len_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else if (i_rvalid) begin
      len_cnt_q <= len_cnt_cur;
      if (i_rx_last && !wr_drop && (len_cnt_cur != SYM_LEN_CNT))
        len_err_q <= 1'b1;
    end
  end

  assign o_len_err = len_err_q;
`else
  assign o_len_err = 1'b0;
`endif

  // ---------------------------------------------------------------- read FSM
  rd_state_t             state_q, state_d;
  logic                  rd_bank_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_vld_q;
  logic                  rd_sop_q;
  logic                  rd_eop_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  rd_load;
  logic                  rd_issue;
  logic                  rd_done;
  logic                  credit_ok;
  logic [2:0]            fifo_cnt_q;

  // Occupancy plus the one in-flight RAM read must stay below the FIFO depth.
  assign credit_ok = ((fifo_cnt_q + 3'(rd_vld_q)) < 3'd4);

  always_comb begin
    state_d  = state_q;
    rd_load  = 1'b0;
    rd_issue = 1'b0;
    rd_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_load = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            rd_done = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    full_clr[0] = rd_done && !rd_bank_q;
    full_clr[1] = rd_done &&  rd_bank_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_sop_q  <= 1'b0;
      rd_eop_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_issue;
      if (rd_load)
        rd_addr_q <= '0;
      else if (rd_issue)
        rd_addr_q <= rd_addr_q + 1'b1;
      if (rd_done)
        rd_bank_q <= ~rd_bank_q;
      if (rd_issue) begin
        rd_sop_q <= (rd_addr_q == '0);
        rd_eop_q <= (rd_addr_q == LAST_ADDR);
      end
    end
  end

  // ---------------------------------------------------------------- bank RAM
  logic [DATA_WIDTH-1:0] ram [2][SYM_LEN];

  always_ff @(posedge i_clk) begin
    if (wr_en)
      ram[wr_bank_q][i_rx_addr] <= i_rx_data;
    if (rd_issue)
      rd_data_q <= ram[rd_bank_q][rd_addr_q];
  end

  // ---------------------------------------------------------------- output FIFO
  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [3:0]            fifo_sop;
  logic [3:0]            fifo_eop;
  logic [1:0]            fifo_wp_q;
  logic [1:0]            fifo_rp_q;
  logic [7:0]            sym_cnt_q;
  logic                  fifo_valid;
  logic                  push;
  logic                  pop;

  assign fifo_valid = (fifo_cnt_q != 3'd0);
  assign push       = rd_vld_q;
  assign pop        = fifo_valid && i_tready;

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_data[fifo_wp_q] <= rd_data_q;
      fifo_sop[fifo_wp_q]  <= rd_sop_q;
      fifo_eop[fifo_wp_q]  <= rd_eop_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      fifo_cnt_q <= '0;
      sym_cnt_q  <= '0;
    end else begin
      if (push)
        fifo_wp_q <= fifo_wp_q + 1'b1;
      if (pop)
        fifo_rp_q <= fifo_rp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (pop && fifo_eop[fifo_rp_q])
        sym_cnt_q <= sym_cnt_q + 1'b1;
    end
  end

  // Head fields are masked so every output reads 0 while empty, including straight out of reset.
  assign o_tx_valid = fifo_valid;
  assign o_tx_data  = fifo_valid ? fifo_data[fifo_rp_q] : '0;
  assign o_tx_sop   = fifo_valid && fifo_sop[fifo_rp_q];
  assign o_tx_eop   = fifo_valid && fifo_eop[fifo_rp_q];
  assign o_sym_cnt  = sym_cnt_q;
  assign o_overflow = overflow_q;
  assign o_addr_err = addr_err_q;

endmodule
